fp_addsub_pipe: RTL

//  Pipelined, parametrised IEEE-754-style add/subtract unit with valid/ready handshakes.

---
 rtl/fp_addsub_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract with valid/ready flow control.
// S1 swaps the operands so X has the larger magnitude, then aligns Y with guard/round/sticky bits.
// S2 adds or subtracts the significands. S3 normalises the sum, packs the result and sets the flags.
// The whole pipe stalls together whenever the output register is full and not consumed.
module fp_addsub_pipe #(
  parameter int BIT_WIDTH  = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a_operand,
  input  logic [BIT_WIDTH-1:0] b_operand,
  input  logic                 sub_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 exception,
  output logic                 overflow
);

  localparam int SW  = MANT_WIDTH + 1;       // significand with hidden bit
  localparam int AW  = SW + 3;               // significand plus guard/round/sticky
  localparam int LZW = $clog2(AW + 1);
  localparam int XW  = EXP_WIDTH + 2;        // headroom for exponent under/overflow
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  logic                 w_adv;
  logic [3:1]           r_vld_pipe;

  // S1 signals
  logic                 w_a_is_x, w_b_sign, w_x_sign, w_y_sign, w_exc_in;
  logic [EXP_WIDTH-1:0] w_a_exp, w_b_exp, w_x_exp, w_y_exp, w_shift;
  logic [MANT_WIDTH-1:0] w_x_mant, w_y_mant;
  logic [SW-1:0]        w_x_sig, w_y_sig;
  logic [2*SW+1:0]      w_y_wide;
  logic [AW-1:0]        w_y_al;
  logic                 r1_sign, r1_sub, r1_exc;
  logic [EXP_WIDTH-1:0] r1_exp;
  logic [SW-1:0]        r1_sigx;
  logic [AW-1:0]        r1_sigy;

  // S2 signals
  logic [AW:0]          w_sum;
  logic                 r2_sign, r2_exc;
  logic [EXP_WIDTH-1:0] r2_exp;
  logic [AW:0]          r2_sum;

  // S3 signals
  logic                 w_carry, w_uflow, w_oflow, w_ovf;
  logic [LZW-1:0]       w_lz;
  logic [AW-1:0]        w_norm;
  logic [XW-1:0]        w_exp_n;
  logic [MANT_WIDTH-1:0] w_mant;
  logic [BIT_WIDTH-1:0] w_res;
  logic                 w_unused;
  logic [BIT_WIDTH-1:0] r_result;
  logic                 r_exc, r_ovf;

  assign w_adv     = !r_vld_pipe[3] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[3];
  assign result    = r_result;
  assign exception = r_exc;
  assign overflow  = r_ovf;

  // ---------------- S1: swap and align ----------------
  assign w_a_exp  = a_operand[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_b_exp  = b_operand[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_b_sign = b_operand[BIT_WIDTH-1] ^ sub_op;
  assign w_a_is_x = a_operand[BIT_WIDTH-2:0] >= b_operand[BIT_WIDTH-2:0];
  assign w_exc_in = (w_a_exp == EXP_ONES) | (w_b_exp == EXP_ONES);

  // Route the larger magnitude to X; ties keep A as X
  always_comb begin
    w_x_sign = a_operand[BIT_WIDTH-1];
    w_x_exp  = w_a_exp;
    w_x_mant = a_operand[MANT_WIDTH-1:0];
    w_y_sign = w_b_sign;
    w_y_exp  = w_b_exp;
    w_y_mant = b_operand[MANT_WIDTH-1:0];
    if (!w_a_is_x) begin
      w_x_sign = w_b_sign;
      w_x_exp  = w_b_exp;
      w_x_mant = b_operand[MANT_WIDTH-1:0];
      w_y_sign = a_operand[BIT_WIDTH-1];
      w_y_exp  = w_a_exp;
      w_y_mant = a_operand[MANT_WIDTH-1:0];
    end
  end

  // Zero exponent means zero: subnormals lose their significand here
  assign w_x_sig  = (w_x_exp == '0) ? '0 : {1'b1, w_x_mant};
  assign w_y_sig  = (w_y_exp == '0) ? '0 : {1'b1, w_y_mant};
  assign w_shift  = w_x_exp - w_y_exp;
  // Top SW+2 bits are the aligned significand plus guard/round; anything below folds into sticky
  assign w_y_wide = {w_y_sig, {(SW+2){1'b0}}} >> w_shift;
  assign w_y_al   = (int'(w_shift) >= SW) ? '0
                  : {w_y_wide[2*SW+1 -: SW+2], |w_y_wide[SW-1:0]};

  // Valid shift register, advancing only when the output slot frees up
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
  end

  // S1 register: swapped/aligned operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_sign <= 1'b0; r1_sub <= 1'b0; r1_exc <= 1'b0;
      r1_exp  <= '0;   r1_sigx <= '0;  r1_sigy <= '0;
    end else if (w_adv) begin
      r1_sign <= w_x_sign;
      r1_sub  <= w_x_sign ^ w_y_sign;
      r1_exc  <= w_exc_in;
      r1_exp  <= w_x_exp;
      r1_sigx <= w_x_sig;
      r1_sigy <= w_y_al;
    end
  end

  // ---------------- S2: add / subtract ----------------
  // X >= Y in magnitude, so the subtract never goes negative
  assign w_sum = r1_sub ? ({1'b0, r1_sigx, 3'b000} - {1'b0, r1_sigy})
                        : ({1'b0, r1_sigx, 3'b000} + {1'b0, r1_sigy});

  // S2 register: raw sum with carry and GRS bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_sign <= 1'b0; r2_exc <= 1'b0; r2_exp <= '0; r2_sum <= '0;
    end else if (w_adv) begin
      r2_sign <= r1_sign;
      r2_exc  <= r1_exc;
      r2_exp  <= r1_exp;
      r2_sum  <= w_sum;
    end
  end

  // ---------------- S3: normalise and pack ----------------
  assign w_carry = r2_sum[AW];

  // Leading-zero count below the carry bit; highest set bit wins
  always_comb begin
    w_lz = LZW'(AW);
    for (int i = 0; i < AW; i++)
      if (r2_sum[i]) w_lz = LZW'(AW - 1 - i);
  end

  assign w_norm   = r2_sum[AW-1:0] << w_lz;
  assign w_exp_n  = w_carry ? (XW'(r2_exp) + XW'(1)) : (XW'(r2_exp) - XW'(w_lz));
  assign w_uflow  = w_exp_n[XW-1] | (w_exp_n == '0);
  assign w_oflow  = !w_exp_n[XW-1] && (w_exp_n >= XW'(EXP_ONES));
  // Truncation: GRS bits are simply dropped after normalisation
  assign w_mant   = w_carry ? r2_sum[AW-1 -: MANT_WIDTH] : w_norm[AW-2 -: MANT_WIDTH];
  assign w_unused = ^{w_norm[AW-1], w_norm[2:0]};

  // Special-case priority: exception, exact zero, underflow flush, saturation
  always_comb begin
    w_ovf = 1'b0;
    w_res = {r2_sign, w_exp_n[EXP_WIDTH-1:0], w_mant};
    if (r2_exc)
      w_res = '0;
    else if (r2_sum == '0)
      w_res = '0;
    else if (w_uflow)
      w_res = {r2_sign, {(BIT_WIDTH-1){1'b0}}};
    else if (w_oflow) begin
      w_ovf = 1'b1;
      w_res = {r2_sign, EXP_ONES, {MANT_WIDTH{1'b0}}};
    end
  end

  // Output register; empty slots carry zero result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0; r_exc <= 1'b0; r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_result <= r_vld_pipe[2] ? w_res  : '0;
      r_exc    <= r_vld_pipe[2] & r2_exc;
      r_ovf    <= r_vld_pipe[2] & w_ovf;
    end
  end

endmodule
